// File: rtl/sram_ctrl_32_pkg.sv
// rtl/sram_ctrl_32_pkg.sv - state encoding, half select and timing defaults for sram_ctrl_32
package sram_ctrl_32_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_LO     = 3'd4,
    R_HI     = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam int DEF_WE_CYCLES = 2;
  localparam int DEF_RD_CYCLES = 2;

  function automatic int timer_width(input int we_cycles, input int rd_cycles);
    int m;
    m = (we_cycles > rd_cycles) ? we_cycles : rd_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter with zero flag for peripheral phase sequencing
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_ctrl_32.sv
// rtl/sram_ctrl_32.sv - 32-bit CPU bus to 16-bit async SRAM sequencer with registered strobes
module sram_ctrl_32
  import sram_ctrl_32_pkg::*;
#(
  parameter int ADDR_W    = 18,
  parameter bit WIDE      = 1'b1,
  parameter int WE_CYCLES = DEF_WE_CYCLES,
  parameter int RD_CYCLES = DEF_RD_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_adr,
  output logic              sram_cs_b,
  output logic              sram_oe_b,
  output logic              sram_we_b,
  output logic [15:0]       sram_dout,
  output logic              sram_dout_en,
  input  logic [15:0]       sram_din
);

  localparam int TW = timer_width(WE_CYCLES, RD_CYCLES);
  localparam logic [TW-1:0] WE_LOAD = TW'(WE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LOAD = TW'(RD_CYCLES - 1);

  state_t            state, state_nx;
  logic              half, half_nx;
  logic              t_load, t_zero;
  logic [TW-1:0]     t_val;
  logic [ADDR_W-1:0] adr_nx;
  logic              phase_entry;

  sram_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_val),
    .zero     (t_zero)
  );

  always_comb begin
    state_nx = state;
    half_nx  = half;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_nx = rnw ? R_LO : W_SETUP;
          half_nx  = HALF_LO;
        end
      end
      W_SETUP:  state_nx = W_STROBE;
      W_STROBE: if (t_zero) state_nx = W_HOLD;
      W_HOLD: begin
        if (WIDE && half == HALF_LO) begin
          state_nx = W_SETUP;
          half_nx  = HALF_HI;
        end else begin
          state_nx = DONE;
        end
      end
      R_LO: begin
        if (t_zero) begin
          if (WIDE) begin
            state_nx = R_HI;
            half_nx  = HALF_HI;
          end else begin
            state_nx = DONE;
          end
        end
      end
      R_HI:    if (t_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Timer and address only move on entry to a phase, so strobes never see a changing address.
  assign phase_entry = (state_nx != state);
  assign t_load = phase_entry &&
                  (state_nx == W_STROBE || state_nx == R_LO || state_nx == R_HI);
  assign t_val  = (state_nx == W_STROBE) ? WE_LOAD : RD_LOAD;
  assign adr_nx = WIDE ? {addr[ADDR_W-2:0], half_nx} : addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      half         <= HALF_LO;
      ack          <= 1'b0;
      busy         <= 1'b0;
      rdata        <= '0;
      sram_adr     <= '0;
      sram_cs_b    <= 1'b1;
      sram_oe_b    <= 1'b1;
      sram_we_b    <= 1'b1;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
    end else begin
      state        <= state_nx;
      half         <= half_nx;
      ack          <= (state_nx == DONE);
      busy         <= (state_nx != IDLE);
      sram_cs_b    <= (state_nx == IDLE);
      sram_oe_b    <= !(state_nx == R_LO || state_nx == R_HI);
      sram_we_b    <= (state_nx != W_STROBE);
      sram_dout_en <= (state_nx == W_SETUP || state_nx == W_STROBE || state_nx == W_HOLD);
      if (phase_entry && (state_nx == W_SETUP || state_nx == R_LO || state_nx == R_HI)) begin
        sram_adr <= adr_nx;
      end
      if (state_nx == W_SETUP) begin
        sram_dout <= (half_nx == HALF_HI) ? wdata[31:16] : wdata[15:0];
      end
      if (state == R_LO && t_zero) begin
        if (WIDE) rdata[15:0] <= sram_din;
        else      rdata       <= {16'h0000, sram_din};
      end
      if (state == R_HI && t_zero) begin
        rdata[31:16] <= sram_din;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl_32.sv
// tb/tb_sram_ctrl_32.sv - randomized self-checking bench for sram_ctrl_32, wide and narrow builds
module tb_sram_ctrl_32;

  localparam int AW = 18;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   v;
    int            n;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req [2];
  logic          rnw [2];
  logic [AW-1:0] addr [2];
  logic [31:0]   wdata [2];
  logic [31:0]   rdata [2];
  logic          ack [2];
  logic          busy [2];
  logic [AW-1:0] sram_adr [2];
  logic          cs_b [2];
  logic          oe_b [2];
  logic          we_b [2];
  logic [15:0]   dout [2];
  logic          dout_en [2];
  logic [15:0]   din [2];

  logic [15:0]   sram [2][0:(1<<AW)-1];
  wr_t           wq [2][$];
  int            we_run [2] = '{0, 0};
  logic [AW-1:0] run_a [2];
  logic [15:0]   run_v [2];
  int            oe_low [2] = '{0, 0};
  int            den_cnt [2] = '{0, 0};

  logic [31:0]   ref_w [int];
  logic [15:0]   ref_h [int];
  int            keys [2][$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_ctrl_32 #(.ADDR_W(AW), .WIDE(1'b1), .WE_CYCLES(2), .RD_CYCLES(2)) u_wide (
    .clk(clk), .reset(reset), .req(req[0]), .rnw(rnw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .sram_adr(sram_adr[0]),
    .sram_cs_b(cs_b[0]), .sram_oe_b(oe_b[0]), .sram_we_b(we_b[0]), .sram_dout(dout[0]),
    .sram_dout_en(dout_en[0]), .sram_din(din[0]));

  sram_ctrl_32 #(.ADDR_W(AW), .WIDE(1'b0), .WE_CYCLES(1), .RD_CYCLES(3)) u_narrow (
    .clk(clk), .reset(reset), .req(req[1]), .rnw(rnw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .sram_adr(sram_adr[1]),
    .sram_cs_b(cs_b[1]), .sram_oe_b(oe_b[1]), .sram_we_b(we_b[1]), .sram_dout(dout[1]),
    .sram_dout_en(dout_en[1]), .sram_din(din[1]));

  assign din[0] = oe_b[0] ? 16'h5A5A : sram[0][sram_adr[0]];
  assign din[1] = oe_b[1] ? 16'hA5A5 : sram[1][sram_adr[1]];

  function automatic int p_we(input int d);
    return (d == 0) ? 2 : 1;
  endfunction
  function automatic int p_rd(input int d);
    return (d == 0) ? 2 : 3;
  endfunction
  function automatic int p_h(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SRAM device model: latches on WE rising, plus pin-level protocol observations
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check("bus_conflict", 32'(dout_en[d] & ~oe_b[d]), 32'h0);
      if (!oe_b[d]) oe_low[d]++;
      if (dout_en[d]) den_cnt[d]++;
      if (!we_b[d]) begin
        check("we_dout_en", 32'(dout_en[d]), 32'h1);
        if (we_run[d] == 0) begin
          run_a[d] = sram_adr[d];
          run_v[d] = dout[d];
        end else begin
          check("we_adr_stable", 32'(sram_adr[d]), 32'(run_a[d]));
          check("we_dout_stable", 32'(dout[d]), 32'(run_v[d]));
        end
        we_run[d]++;
      end else if (we_run[d] != 0) begin
        sram[d][run_a[d]] = run_v[d];
        wq[d].push_back('{run_a[d], run_v[d], we_run[d]});
        we_run[d] = 0;
      end
    end
  end

  task automatic access(input int d, input logic r, input logic [AW-1:0] a,
                        input logic [31:0] wd, input bit hold);
    int h, lat, exp_lat, oe0, den0;
    logic [31:0] exp_rd;
    wr_t e;
    h = p_h(d);
    @(negedge clk);
    check("idle_before_req", 32'(busy[d]), 32'h0);
    check("ack_pulse", 32'(ack[d]), 32'h0);
    req[d] = 1'b1;
    rnw[d] = r;
    addr[d] = a;
    wdata[d] = wd;
    oe0 = oe_low[d];
    den0 = den_cnt[d];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check("busy_cycle1", 32'(busy[d]), 32'h1);
        check("cs_b_cycle1", 32'(cs_b[d]), 32'h0);
      end
    end while (!ack[d] && lat < 60);
    if (!hold) req[d] = 1'b0;
    exp_lat = r ? (h * p_rd(d) + 1) : (h * (p_we(d) + 2) + 1);
    check(r ? "read_ack_cycle" : "write_ack_cycle", 32'(lat), 32'(exp_lat));
    if (r) begin
      exp_rd = (d == 0) ? ref_w[int'(a[AW-2:0])] : {16'h0000, ref_h[int'(a)]};
      check("rdata", rdata[d], exp_rd);
      check("oe_low_cycles", 32'(oe_low[d] - oe0), 32'(h * p_rd(d)));
      check("dout_en_in_read", 32'(den_cnt[d] - den0), 32'h0);
    end else begin
      if (d == 0) begin
        ref_w[int'(a[AW-2:0])] = wd;
        keys[0].push_back(int'(a[AW-2:0]));
      end else begin
        ref_h[int'(a)] = wd[15:0];
        keys[1].push_back(int'(a));
      end
      check("dout_en_cycles", 32'(den_cnt[d] - den0), 32'(h * (p_we(d) + 2)));
      check("strobe_count", 32'(wq[d].size()), 32'(h));
      for (int i = 0; i < h; i++) begin
        if (wq[d].size() == 0) break;
        e = wq[d].pop_front();
        check("wr_adr", 32'(e.a), (d == 0) ? 32'({a[AW-2:0], 1'(i)}) : 32'(a));
        check("wr_data", 32'(e.v), (i == 0) ? 32'(wd[15:0]) : 32'(wd[31:16]));
        check("we_low_clocks", 32'(e.n), 32'(p_we(d)));
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic          r;
    bit            hold;
    int            k;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0;
      rnw[d] = 1'b0;
      addr[d] = '0;
      wdata[d] = '0;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("rst_we_b", 32'(we_b[d]), 32'h1);
        check("rst_oe_b", 32'(oe_b[d]), 32'h1);
        check("rst_cs_b", 32'(cs_b[d]), 32'h1);
        check("rst_dout_en", 32'(dout_en[d]), 32'h0);
        check("rst_ack", 32'(ack[d]), 32'h0);
        check("rst_busy", 32'(busy[d]), 32'h0);
        check("rst_rdata", rdata[d], 32'h0);
        check("rst_sram_adr", 32'(sram_adr[d]), 32'h0);
        check("rst_dout", 32'(dout[d]), 32'h0);
      end
    end
    reset = 1'b0;

    access(0, 1'b0, 18'h00123, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 18'h00123, 32'h0, 1'b0);
    access(0, 1'b1, 18'h20123, 32'h0, 1'b0);

    access(0, 1'b0, 18'h00200, 32'h12345678, 1'b1);
    access(0, 1'b1, 18'h00200, 32'h0, 1'b0);

    @(negedge clk);
    req[0] = 1'b1;
    rnw[0] = 1'b0;
    addr[0] = 18'h00500;
    wdata[0] = $urandom;
    repeat (2) @(negedge clk);
    check("strobe_reached", 32'(we_b[0]), 32'h0);
    reset = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check("abort_we_b", 32'(we_b[0]), 32'h1);
    check("abort_dout_en", 32'(dout_en[0]), 32'h0);
    check("abort_busy", 32'(busy[0]), 32'h0);
    check("abort_cs_b", 32'(cs_b[0]), 32'h1);
    check("abort_ack", 32'(ack[0]), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_ack", 32'(ack[0]), 32'h0);
    wq[0].delete();
    access(0, 1'b0, 18'h00500, 32'hA5C3_0F96, 1'b0);
    access(0, 1'b1, 18'h00500, 32'h0, 1'b0);

    access(1, 1'b0, 18'h3FFFF, 32'hCAFE1234, 1'b0);
    access(1, 1'b1, 18'h3FFFF, 32'h0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 30; i++) begin
        r = (keys[d].size() > 0) && ($urandom_range(0, 1) == 1);
        hold = (i != 29) && ($urandom_range(0, 2) == 0);
        wd = $urandom;
        if (r) begin
          k = keys[d][$urandom_range(0, keys[d].size() - 1)];
          if (d == 0) a = {1'($urandom), 17'(k)};
          else        a = AW'(k);
        end else begin
          a = AW'($urandom);
        end
        access(d, r, a, wd, hold);
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
